i_decode: RTL

I_DECODE -- requirements
Module: i_decode

---
 rtl/i_decode.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/i_decode.sv
// ============================================================================
// Module   : i_decode
// Purpose  : Fetches instruction words, decodes R/I/L/S/B fields and pushes
//            them to the instruction buffer; stalls on branches until resolved.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i_decode #(
    parameter int          XLEN       = 32,
    parameter int          OPT_WID    = 7,
    parameter int          FUNCT3_WID = 3,
    parameter int          REG_WID    = 5,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  im_req,
    output logic [XLEN-1:0]       im_addr,
    input  logic                  im_ready,
    input  logic [XLEN-1:0]       im_inst,
    input  logic                  id_vacant,
    output logic                  id_valid,
    output logic [OPT_WID-1:0]    id_opt,
    output logic [FUNCT3_WID-1:0] id_funct,
    output logic [REG_WID-1:0]    id_rs1,
    output logic [REG_WID-1:0]    id_rs2,
    output logic [REG_WID-1:0]    id_rd,
    output logic [XLEN-1:0]       id_imm,
    input  logic                  br_valid,
    input  logic                  br_taken,
    input  logic [XLEN-1:0]       br_target
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_SEND    = 3'd2,
        S_HOLD    = 3'd3,
        S_BR_WAIT = 3'd4
    } state_t;

    localparam logic [OPT_WID-1:0] OP_R = 7'b0110011;
    localparam logic [OPT_WID-1:0] OP_I = 7'b0010011;
    localparam logic [OPT_WID-1:0] OP_L = 7'b0000011;
    localparam logic [OPT_WID-1:0] OP_S = 7'b0100011;
    localparam logic [OPT_WID-1:0] OP_B = 7'b1100011;
    localparam logic [XLEN-1:0]    PC_STEP = XLEN'(4);

    state_t                  state_q, state_d;
    logic [XLEN-1:0]         pc_q, pc_d;
    logic [XLEN-1:0]         inst_q, inst_d;
    logic                    im_req_q, im_req_d;
    logic                    id_valid_q, id_valid_d;
    logic [OPT_WID-1:0]      opt_q, opt_d;
    logic [FUNCT3_WID-1:0]   funct_q, funct_d;
    logic [REG_WID-1:0]      rs1_q, rs1_d;
    logic [REG_WID-1:0]      rs2_q, rs2_d;
    logic [REG_WID-1:0]      rd_q, rd_d;
    logic [XLEN-1:0]         imm_q, imm_d;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        im_req_d   = im_req_q;
        id_valid_d = 1'b0;
        opt_d      = opt_q;
        funct_d    = funct_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        imm_d      = imm_q;

        case (state_q)
            S_FETCH: begin
                // A response only counts once the request is actually on the bus
                im_req_d = 1'b1;
                if (im_req_q && im_ready) begin
                    inst_d   = im_inst;
                    im_req_d = 1'b0;
                    state_d  = S_DECODE;
                end
            end

            S_DECODE: begin
                state_d = S_SEND;
                opt_d   = inst_q[6:0];
                funct_d = inst_q[14:12];
                rs1_d   = inst_q[19:15];
                rs2_d   = inst_q[24:20];
                rd_d    = inst_q[11:7];
                case (inst_q[6:0])
                    OP_R: imm_d = '0;
                    OP_I, OP_L: begin
                        rs2_d = '0;
                        imm_d = {{(XLEN-12){inst_q[31]}}, inst_q[31:20]};
                    end
                    OP_S: begin
                        rd_d  = '0;
                        imm_d = {{(XLEN-12){inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
                    end
                    OP_B: begin
                        rd_d  = '0;
                        imm_d = {{(XLEN-13){inst_q[31]}}, inst_q[31], inst_q[7],
                                 inst_q[30:25], inst_q[11:8], 1'b0};
                    end
                    default: begin
                        // Unsupported opcode: leave the published fields untouched
                        opt_d    = opt_q;
                        funct_d  = funct_q;
                        rs1_d    = rs1_q;
                        rs2_d    = rs2_q;
                        rd_d     = rd_q;
                        pc_d     = pc_q + PC_STEP;
                        im_req_d = 1'b1;
                        state_d  = S_FETCH;
                    end
                endcase
            end

            S_SEND: begin
                if (id_vacant) begin
                    id_valid_d = 1'b1;
                    state_d    = S_HOLD;
                end
            end

            S_HOLD: begin
                if (opt_q == OP_B) begin
                    state_d = S_BR_WAIT;
                end else begin
                    pc_d     = pc_q + PC_STEP;
                    im_req_d = 1'b1;
                    state_d  = S_FETCH;
                end
            end

            S_BR_WAIT: begin
                if (br_valid) begin
                    pc_d     = br_taken ? br_target : pc_q + PC_STEP;
                    im_req_d = 1'b1;
                    state_d  = S_FETCH;
                end
            end

            default: begin
                state_d  = S_FETCH;
                im_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            inst_q     <= '0;
            im_req_q   <= 1'b0;
            id_valid_q <= 1'b0;
            opt_q      <= '0;
            funct_q    <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            imm_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            im_req_q   <= im_req_d;
            id_valid_q <= id_valid_d;
            opt_q      <= opt_d;
            funct_q    <= funct_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            imm_q      <= imm_d;
        end
    end

    assign im_req   = im_req_q;
    assign im_addr  = pc_q;
    assign id_valid = id_valid_q;
    assign id_opt   = opt_q;
    assign id_funct = funct_q;
    assign id_rs1   = rs1_q;
    assign id_rs2   = rs2_q;
    assign id_rd    = rd_q;
    assign id_imm   = imm_q;

endmodule

`default_nettype wire
